imem_loader: RTL
================

Name: imem_loader

Overview:
- Program loader: the write side of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them to consecutive instruction-memory addresses from 0.
- Holds the CPU in reset while loading; releases it once the image is complete.
- Sits between an external byte source (host bridge or bench) and the imem write port / CPU reset input.

Parameters:
- ADDR_W, 5, imem address width; depth = 2**ADDR_W words (32).
- DATA_W, 16, instruction word width; fixed at 16, two bytes per word.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins a load session.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte; a transfer happens when in_valid && in_ready.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  ADDR_W  write address.
- imem_wdata  out  16  write data.
- cpu_rst  out  1  active-high reset to the CPU.
- busy  out  1  session in progress.
- done  out  1  image loaded, CPU released.
- error  out  1  session aborted.
- words_loaded  out  ADDR_W+1  count of words written this session.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, error=0, words_loaded=0, state IDLE.
- Stream format, big-endian: LEN_HI, LEN_LO (16-bit word count N), then N words as HI byte then LO byte; a CKSUM byte follows when the optional feature is enabled.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CKSUM, DONE, ERR.
- in_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CKSUM; 0 elsewhere. in_ready does not depend combinationally on in_valid.
- Transitions:
  - IDLE/DONE/ERR --start--> LEN_HI: cpu_rst=1, busy=1, done=0, error=0, words_loaded=0, address counter=0.
  - start in any other state is ignored.
  - LEN_HI --xfer--> LEN_LO.
  - LEN_LO --xfer--> DATA_HI if 0 < N <= 2**ADDR_W.
  - LEN_LO --xfer--> DONE if N=0 (no writes).
  - LEN_LO --xfer--> ERR if N > 2**ADDR_W.
  - DATA_HI --xfer--> DATA_LO: high byte latched.
  - DATA_LO --xfer--> DATA_HI while words remain; otherwise to CKSUM (feature on) or DONE.
- Write timing: imem_we pulses for exactly one cycle, in the cycle after the DATA_LO transfer. imem_waddr and imem_wdata are valid in that same cycle. words_loaded increments in that same cycle.
- Back-to-back transfers at one byte per cycle are sustained with no stall. in_valid gaps are tolerated in any state.
- DONE: cpu_rst=0, busy=0, done=1. cpu_rst deasserts in the cycle the final imem_we is high, so the last write is committed before the CPU's first fetch edge.
- ERR: cpu_rst=1, busy=0, error=1. No further writes. Exit only via start or rst_n.
- Address wraps never occur: the N bound check guarantees this.
- Reset mid-load (asynchronous): all outputs return to reset values immediately. Words already written stay in imem. The CPU stays in reset until a full reload completes.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- With the macro: a running XOR of all bytes from LEN_HI through the last DATA_LO is kept. After the last word the loader enters CKSUM. If the CKSUM byte equals the running XOR, go to DONE; otherwise go to ERR. Words already written remain in imem.
- Without the macro: the CKSUM state and the accumulator are absent; the last DATA_LO goes directly to DONE.

Decomposition:
- Package loader_pkg holds:
  - the state enum;
  - DATA_W;
  - the byte-order constants;
  - ISA opcode constants (NOP=0x0 … JMP=0xA), shared with the CPU decoder and benches.
- One sub-module, loader_cksum: an XOR accumulator with clear/enable, instantiated only under IMEM_LOADER_CKSUM_EN.

Test Plan:
- Start, stream 00 03 61 05 62 03 13 12 with in_valid held high -> writes (0,0x6105), (1,0x6203), (2,0x1312) on three single-cycle imem_we pulses; words_loaded=3; done=1; cpu_rst falls with the third write.
- Start, stream 00 00 -> zero writes; done=1 and cpu_rst=0 one cycle after the LEN_LO transfer.
- Start, stream 00 21 (N=33, ADDR_W=5) -> error=1, cpu_rst stays 1, in_ready=0, no imem_we; a later start recovers.
- Same image as the first scenario with random 0–3 cycle in_valid gaps and start pulsed mid-load -> identical writes; start is ignored.
- rst_n low after the second word -> immediate reset values and cpu_rst=1; a full reload then completes normally.
- With IMEM_LOADER_CKSUM_EN, image 00 01 A0 00: CKSUM byte A1 -> done; CKSUM byte A0 -> error with word 0 already written.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared loader/CPU definitions: loader FSM states, word geometry, stream byte order, ISA opcodes.
// The CKSUM state exists only when IMEM_LOADER_CKSUM_EN is defined.
package loader_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  // Big-endian stream: the first byte of each pair is the high byte.
  localparam int HI_LSB = 8;
  localparam int LO_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_BEQ = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
`ifdef IMEM_LOADER_CKSUM_EN
    CKSUM,
`endif
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/loader_cksum.sv
// Running XOR of accepted stream bytes; cleared at session start.
module loader_cksum
  import loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_din,
  output logic [BYTE_W-1:0] o_acc
);

  logic [BYTE_W-1:0] r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc ^ i_din;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader: byte stream -> 16-bit imem writes, holds the CPU in reset while loading.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [15:0] MAX_N = 16'(2 ** ADDR_W);

  state_t            r_state;
  state_t            w_next;
  logic [BYTE_W-1:0] r_len_hi;
  logic [BYTE_W-1:0] r_hi;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_words;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_ready;
  logic              w_xfer;
  logic              w_start_ok;
  logic [15:0]       w_len;
  logic [ADDR_W:0]   w_words_inc;
  logic              w_last;

  assign w_ready = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                   (r_state == DATA_HI) || (r_state == DATA_LO)
`ifdef IMEM_LOADER_CKSUM_EN
                   || (r_state == CKSUM)
`endif
                   ;
  assign w_xfer      = in_valid && w_ready;
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_len       = {r_len_hi, in_data};
  assign w_words_inc = r_words + 1'b1;
  assign w_last      = (w_words_inc == r_len);

`ifdef IMEM_LOADER_CKSUM_EN
  logic [BYTE_W-1:0] w_cksum;
  logic              w_ck_en;

  assign w_ck_en = w_xfer && (r_state != CKSUM);

  loader_cksum u_cksum (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_start_ok),
    .i_en    (w_ck_en),
    .i_din   (in_data),
    .o_acc   (w_cksum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start) w_next = LEN_HI;
      LEN_HI:          if (w_xfer) w_next = LEN_LO;
      LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 16'd0)     w_next = DONE;
          else if (w_len > MAX_N) w_next = ERR;
          else                    w_next = DATA_HI;
        end
      end
      DATA_HI:         if (w_xfer) w_next = DATA_LO;
      DATA_LO: begin
        if (w_xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
          w_next = w_last ? CKSUM : DATA_HI;
`else
          w_next = w_last ? DONE : DATA_HI;
`endif
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM:           if (w_xfer) w_next = (in_data == w_cksum) ? DONE : ERR;
`endif
      default:         w_next = IDLE;
    endcase
  end

  // The word count doubles as the write-address counter; the length bound keeps it from wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_hi <= '0;
      r_hi     <= '0;
      r_len    <= '0;
      r_words  <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) r_words <= '0;
      if (w_xfer) begin
        case (r_state)
          LEN_HI:  r_len_hi <= in_data;
          LEN_LO:  r_len    <= w_len[ADDR_W:0];
          DATA_HI: r_hi     <= in_data;
          DATA_LO: begin
            r_we    <= 1'b1;
            r_waddr <= r_words[ADDR_W-1:0];
            r_wdata <= {r_hi, in_data};
            r_words <= w_words_inc;
          end
          default: ;
        endcase
      end
    end
  end

  // Entering DONE on the last-word edge drops cpu_rst in the same cycle as the final imem_we.
  assign in_ready     = w_ready;
  assign busy         = w_ready;
  assign done         = (r_state == DONE);
  assign error        = (r_state == ERR);
  assign cpu_rst      = (r_state != DONE);
  assign imem_we      = r_we;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words;

endmodule
